// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer: CTRL/PRESET/COUNT registers, a four-state
// sequencer and a maskable interrupt that is held (one-shot) or pulsed (auto-reload).
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    // state | meaning
    // IDLE  | waiting for EN
    // LOAD  | copy PRESET into COUNT
    // CNT   | decrement COUNT until the terminal count (0)
    // INT   | terminal count reached; reload (MODE=01) or stop and clear EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t      state;
    state_t      state_nx;
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_nx;
    logic        pending;
    logic        pending_nx;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        term_cnt;
    logic        pend_set;
    logic        pend_clr_fsm;
    logic        en_clr;

    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_preset = we && (addr == ADDR_PRESET);
    assign term_cnt  = (count == 32'd0);

    always_comb begin
        state_nx     = state;
        count_nx     = count;
        pend_set     = 1'b0;
        pend_clr_fsm = 1'b0;
        en_clr       = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nx = LOAD;
            end
            LOAD: begin
                count_nx = preset;
                state_nx = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nx = IDLE;
                end else if (!term_cnt) begin
                    count_nx = count - 32'd1;
                end else begin
                    state_nx = INT;
                    pend_set = 1'b1;
                end
            end
            INT: begin
                // reserved modes 10/11 fall through to one-shot behaviour
                if (mode == MODE_RELOAD) begin
                    state_nx     = LOAD;
                    pend_clr_fsm = 1'b1;
                end else begin
                    state_nx = IDLE;
                    en_clr   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // a same-edge set beats any clear
    always_comb begin
        pending_nx = pending;
        if (pend_set)
            pending_nx = 1'b1;
        else if (wr_ctrl || wr_preset || pend_clr_fsm)
            pending_nx = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= 32'd0;
            pending <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            pending <= pending_nx;
        end
    end

    // a software write of EN overrides the one-shot auto-clear on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en   <= 1'b0;
            mode <= 2'b00;
            im   <= 1'b0;
        end else if (wr_ctrl && be[0]) begin
            en   <= din[0];
            mode <= din[2:1];
            im   <= din[3];
        end else if (en_clr) begin
            en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) preset[8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            ADDR_CTRL:   dout = {28'd0, im, mode, en};
            ADDR_PRESET: dout = preset;
            ADDR_COUNT:  dout = count;
            default:     dout = 32'd0;
        endcase
    end

    assign irq = im & pending;

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: expected values are queued as stimulus is
// planned and popped when the corresponding DUT output is sampled.
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int          checks;
    int          errors;
    logic [31:0] sb[$];
    logic [31:0] exp_v;

    timer_dev dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .be   (be),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; din = d; be = b; we = 1'b1;
        tick();
        we = 1'b0; be = 4'h0;
    endtask

    task automatic rd(input logic [1:0] a);
        addr = a;
        #1;
    endtask

    task automatic do_reset();
        we = 1'b0; addr = 2'd0; be = 4'h0; din = 32'd0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        we = 1'b0; addr = 2'd0; be = 4'h0; din = 32'd0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 4; a++) sb.push_back(32'd0);
        sb.push_back(32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0]);
            exp_v = sb.pop_front(); checks++;
            if (dout !== exp_v) begin errors++; $display("FAIL reset_dout addr=%0d got %h want %h", a, dout, exp_v); end
        end
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL reset_irq got %b want %h", irq, exp_v); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_one_shot();
        do_reset();
        wr(2'd1, 32'd3, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        tick();
        sb.push_back(32'd3); sb.push_back(32'd2); sb.push_back(32'd1); sb.push_back(32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(); rd(2'd2);
            exp_v = sb.pop_front(); checks++;
            if (dout !== exp_v) begin errors++; $display("FAIL one_shot_count step%0d got %h want %h", i, dout, exp_v); end
        end
        sb.push_back(32'd1);
        tick();
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL one_shot_irq_set got %b want %h", irq, exp_v); end
        sb.push_back(32'h8); sb.push_back(32'd1);
        tick(); rd(2'd0);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL one_shot_en_clear got %h want %h", dout, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL one_shot_irq_e7 got %b want %h", irq, exp_v); end
        sb.push_back(32'd1);
        repeat (3) tick();
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL one_shot_irq_held got %b want %h", irq, exp_v); end
        sb.push_back(32'd0);
        wr(2'd0, 32'h8, 4'hF);
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL one_shot_irq_clear got %b want %h", irq, exp_v); end
    endtask

    task automatic test_auto_reload();
        do_reset();
        wr(2'd1, 32'd2, 4'hF);
        wr(2'd0, 32'hB, 4'hF);
        for (int k = 1; k <= 16; k++) begin
            sb.push_back((k % 5 == 0) ? 32'd1 : 32'd0);
            if (k % 5 == 2) sb.push_back(32'd2);
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_v = sb.pop_front(); checks++;
            if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL reload_irq E%0d got %b want %h", k, irq, exp_v); end
            if (k % 5 == 2) begin
                rd(2'd2);
                exp_v = sb.pop_front(); checks++;
                if (dout !== exp_v) begin errors++; $display("FAIL reload_count E%0d got %h want %h", k, dout, exp_v); end
            end
        end
        wr(2'd0, 32'h0, 4'hF);
    endtask

    task automatic test_byte_enables();
        do_reset();
        sb.push_back(32'h00BB00DD); sb.push_back(32'h11BB33DD); sb.push_back(32'd0);
        sb.push_back(32'd0); sb.push_back(32'h11BB33DD); sb.push_back(32'd0); sb.push_back(32'h6);
        wr(2'd1, 32'hAABBCCDD, 4'b0101); rd(2'd1);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL be_preset_a got %h want %h", dout, exp_v); end
        wr(2'd1, 32'h11223344, 4'b1010); rd(2'd1);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL be_preset_b got %h want %h", dout, exp_v); end
        wr(2'd2, 32'h1234, 4'hF); rd(2'd2);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL count_write_ignored got %h want %h", dout, exp_v); end
        wr(2'd3, 32'hFFFFFFFF, 4'hF); rd(2'd3);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL addr3_read got %h want %h", dout, exp_v); end
        rd(2'd1);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL addr3_no_alias got %h want %h", dout, exp_v); end
        wr(2'd0, 32'hF, 4'b1110); rd(2'd0);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL ctrl_be0_off got %h want %h", dout, exp_v); end
        wr(2'd0, 32'hFFFFFFF6, 4'hF); rd(2'd0);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL ctrl_unused_bits got %h want %h", dout, exp_v); end
        wr(2'd0, 32'h0, 4'hF);
    endtask

    task automatic test_mask_abort();
        do_reset();
        wr(2'd1, 32'd1, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        for (int k = 1; k <= 6; k++) sb.push_back(32'd0);
        sb.push_back(32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_v = sb.pop_front(); checks++;
            if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL masked_irq E%0d got %b want %h", k, irq, exp_v); end
        end
        rd(2'd0);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL masked_en_clear got %h want %h", dout, exp_v); end
        wr(2'd1, 32'd10, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        sb.push_back(32'd10); sb.push_back(32'd9); sb.push_back(32'd8);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick(); rd(2'd2);
            exp_v = sb.pop_front(); checks++;
            if (dout !== exp_v) begin errors++; $display("FAIL abort_count step%0d got %h want %h", i, dout, exp_v); end
        end
        wr(2'd0, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) sb.push_back(32'd7);
        for (int i = 0; i < 3; i++) begin
            tick(); rd(2'd2);
            exp_v = sb.pop_front(); checks++;
            if (dout !== exp_v) begin errors++; $display("FAIL abort_freeze step%0d got %h want %h", i, dout, exp_v); end
        end
        wr(2'd1, 32'd20, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        tick();
        wr(2'd0, 32'h0, 4'hF);
        sb.push_back(32'd20); sb.push_back(32'd20);
        for (int i = 0; i < 2; i++) begin
            tick(); rd(2'd2);
            exp_v = sb.pop_front(); checks++;
            if (dout !== exp_v) begin errors++; $display("FAIL load_then_disable step%0d got %h want %h", i, dout, exp_v); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        wr(2'd1, 32'd5, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        repeat (4) tick();
        sb.push_back(32'd3);
        rd(2'd2);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL pre_reset_count got %h want %h", dout, exp_v); end
        #2 reset = 1'b0;
        for (int a = 0; a < 4; a++) sb.push_back(32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0]);
            exp_v = sb.pop_front(); checks++;
            if (dout !== exp_v) begin errors++; $display("FAIL async_dout addr=%0d got %h want %h", a, dout, exp_v); end
        end
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        repeat (4) tick();
        sb.push_back(32'd0); sb.push_back(32'd0);
        rd(2'd2);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL post_reset_count got %h want %h", dout, exp_v); end
        rd(2'd0);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL post_reset_ctrl got %h want %h", dout, exp_v); end
        wr(2'd0, 32'h9, 4'hF);
        repeat (3) tick();
        sb.push_back(32'd1); sb.push_back(32'd0);
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL pre_reset_irq got %b want %h", irq, exp_v); end
        #3 reset = 1'b0;
        #1;
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL async_irq got %b want %h", irq, exp_v); end
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
    endtask

    task automatic test_boundaries();
        do_reset();
        wr(2'd0, 32'h9, 4'hF);
        sb.push_back(32'd0); sb.push_back(32'd1); sb.push_back(32'h8);
        tick(); tick();
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL preset0_irq_e2 got %b want %h", irq, exp_v); end
        tick();
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL preset0_irq_e3 got %b want %h", irq, exp_v); end
        tick(); rd(2'd0);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL preset0_en_clear got %h want %h", dout, exp_v); end

        wr(2'd0, 32'h9, 4'hF);
        repeat (3) tick();
        wr(2'd0, 32'h9, 4'hF);
        sb.push_back(32'h9); sb.push_back(32'd0); sb.push_back(32'd1);
        rd(2'd0);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL en_write_wins got %h want %h", dout, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL en_write_clears_irq got %b want %h", irq, exp_v); end
        repeat (3) tick();
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL en_write_restart got %b want %h", irq, exp_v); end
        wr(2'd0, 32'h0, 4'hF);

        do_reset();
        wr(2'd1, 32'd2, 4'hF);
        wr(2'd0, 32'h9, 4'hF);
        repeat (4) tick();
        wr(2'd1, 32'd7, 4'hF);
        sb.push_back(32'd1); sb.push_back(32'd7); sb.push_back(32'd1);
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL set_wins_irq got %b want %h", irq, exp_v); end
        rd(2'd1);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL set_wins_preset got %h want %h", dout, exp_v); end
        tick();
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL set_wins_held got %b want %h", irq, exp_v); end

        do_reset();
        wr(2'd0, 32'hD, 4'hF);
        sb.push_back(32'd1); sb.push_back(32'hC);
        repeat (3) tick();
        exp_v = sb.pop_front(); checks++;
        if ({31'd0, irq} !== exp_v) begin errors++; $display("FAIL mode10_irq got %b want %h", irq, exp_v); end
        tick(); rd(2'd0);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL mode10_one_shot got %h want %h", dout, exp_v); end

        do_reset();
        wr(2'd1, 32'hFFFFFFFF, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        sb.push_back(32'hFFFFFFFF); sb.push_back(32'hFFFFFFFE);
        tick(); tick(); rd(2'd2);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL max_preset_load got %h want %h", dout, exp_v); end
        tick(); rd(2'd2);
        exp_v = sb.pop_front(); checks++;
        if (dout !== exp_v) begin errors++; $display("FAIL max_preset_dec got %h want %h", dout, exp_v); end
        wr(2'd0, 32'h0, 4'hF);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        we     = 1'b0;
        addr   = 2'd0;
        be     = 4'h0;
        din    = 32'd0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_byte_enables();
        test_mask_abort();
        test_async_reset();
        test_boundaries();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-002 Port list SHALL be:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low.
- addr, input, 2: word select, decoded from CPU address bits [3:2].
- we, input, 1: store strobe from the memory stage.
- be, input, 4: byte enables; be[i] covers din[8i+7:8i].
- din, input, 32: store data.
- dout, output, 32: load data.
- irq, output, 1: interrupt request.
REQ-003 Register map SHALL be:
- addr 0 = CTRL, read/write. Bit 0 EN, bits [2:1] MODE, bit 3 IM; all other bits read 0.
- addr 1 = PRESET, read/write, 32 bits.
- addr 2 = COUNT, read-only.
- addr 3 reads 0; writes to addr 3 are ignored.

Function
REQ-004 dout SHALL be combinational from addr and the current register contents, with zero-cycle read latency.
REQ-005 A write SHALL occur on the rising clk edge when we=1. Only bytes whose be bit is 1 are updated.
REQ-006 Writes to COUNT and writes to addr 3 SHALL be ignored.
REQ-007 The state machine SHALL have exactly four states: IDLE, LOAD, CNT, INT. Its reset state is IDLE.
REQ-008 In IDLE, if EN=1 the next state SHALL be LOAD; otherwise it stays in IDLE.
REQ-009 In LOAD, COUNT SHALL take the value of PRESET and the next state is CNT.
REQ-010 In CNT:
- if EN=0, next state IDLE;
- else if COUNT≠0, COUNT decrements by 1 and the state stays in CNT;
- else (COUNT=0), next state INT and the pending flag is set.
REQ-011 In INT with MODE=00 (one-shot), the next state SHALL be IDLE and EN SHALL be cleared. The pending flag is held.
REQ-012 In INT with MODE=01 (auto-reload), the next state SHALL be LOAD and the pending flag is cleared on that edge, giving a one-cycle pulse.
REQ-013 MODE values 10 and 11 SHALL behave as 00.
REQ-014 irq SHALL equal IM AND pending, with no combinational path from the bus inputs.
REQ-015 Any write to CTRL or PRESET SHALL clear pending. If that write coincides with the edge that sets pending, set wins.
REQ-016 If a CTRL write coincides with the INT-state EN auto-clear, the written EN value SHALL win.
REQ-017 A PRESET write during CNT SHALL NOT alter COUNT. The new value takes effect at the next LOAD.
REQ-018 Timing SHALL be as follows, where E0 is the edge that sets EN from IDLE:
- E1: enter LOAD.
- E2: COUNT=PRESET.
- E2+N+1: enter INT, for PRESET=N.
- PRESET=0 enters INT at E3.
REQ-019 COUNT SHALL only count downward and SHALL never wrap below 0. A PRESET of 0xFFFFFFFF SHALL be accepted without overflow.
REQ-020 Clearing EN while in LOAD SHALL still complete the load. The following CNT cycle then returns to IDLE.

Reset
REQ-021 When reset=0, the following SHALL be forced asynchronously: CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE, irq=0.
REQ-022 dout during reset SHALL be 0 for every addr.
REQ-023 Deassertion of reset SHALL take effect at the first rising edge after reset=1. There SHALL be no count activity during reset.
REQ-024 Reset asserted mid-count SHALL abort immediately. After release the block is in IDLE with EN=0 and COUNT=0.

Verification
REQ-025 One-shot: PRESET=3, then CTRL=0x9 (EN, IM, MODE=0) at E0 -> COUNT reads 3,2,1,0 at E2..E5; irq=1 after E6; EN reads 0 after E7; irq held until a CTRL write clears it.
REQ-026 Auto-reload: PRESET=2, CTRL=0xB -> irq one-cycle pulses with a period of 5 cycles (LOAD plus 3 CNT plus INT); COUNT reloads to 2 each period.
REQ-027 Byte enables: write 0xAABBCCDD to PRESET with be=0101 over a PRESET of 0 -> PRESET reads 0x00BB00DD; a write to COUNT is ignored.
REQ-028 Mask and abort: CTRL=0x1 (IM=0) with PRESET=1 -> irq stays 0 while pending sets; write CTRL=0 mid-CNT -> IDLE next edge; COUNT freezes.
REQ-029 Async reset: pull reset low mid-CNT, asynchronously to clk -> all outputs 0 without a clock edge; after release, idle until EN is written.
REQ-030 Boundaries: PRESET=0 -> INT at E3; a PRESET write at the same edge pending sets -> irq asserts (set wins).
